// File: rtl/md_sched_pkg.sv
// Shared encodings for the multiply/divide sequencing controller.
package md_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        WB    = 2'd3
    } md_state_t;

    localparam logic [4:0]  OP_RTYPE     = 5'b00000;
    localparam logic [4:0]  ALU_MULT     = 5'b00110;
    localparam logic [4:0]  ALU_DIV      = 5'b00111;
    localparam logic [4:0]  REG_RSTATUS  = 5'd30;
    localparam logic [31:0] RSTATUS_MULT = 32'd4;
    localparam logic [31:0] RSTATUS_DIV  = 32'd5;

    function automatic logic [31:0] rstatus_code(input logic kind_div);
        return kind_div ? RSTATUS_DIV : RSTATUS_MULT;
    endfunction

endpackage

// File: rtl/md_sched_if.sv
// X-stage request, multdiv unit handshake and writeback bundle for md_sched.
interface md_sched_if;
    logic [4:0]  op;
    logic [4:0]  alu_op;
    logic        issue_valid;
    logic        flush;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ready;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        stall;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport slave (
        input  op, alu_op, issue_valid, flush, operand_a, operand_b, rd,
               md_result, md_exception, md_ready,
        output ctrl_mult, ctrl_div, md_a, md_b, stall, busy,
               wb_valid, wb_rd, wb_data
    );

    modport master (
        output op, alu_op, issue_valid, flush, operand_a, operand_b, rd,
               md_result, md_exception, md_ready,
        input  ctrl_mult, ctrl_div, md_a, md_b, stall, busy,
               wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/md_watchdog_counter.sv
// BUSY-cycle counter; term flags the last cycle the unit is allowed to run.
module md_watchdog_counter #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic term
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CNT_W'(1);
    end

    assign term = (cnt == CNT_W'(MAX_CYCLES - 1));
endmodule

// File: rtl/md_sched.sv
// Launches the shared multdiv unit for R-type mult/div, stalls F/D/X while it
// runs, and issues one writeback (result to rd, or rstatus code to $r30).
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic       clock,
    input  logic       reset,
    md_sched_if.slave  bus
);
    md_state_t   state, state_nxt;
    logic        is_mult, is_div, fire;
    logic        cnt_clr, cnt_en, cnt_term;
    logic        enter_wb, exc_nxt;
    logic        kind_div_q;
    logic [4:0]  rd_q;
    logic        ctrl_mult_q, ctrl_div_q;
    logic [31:0] md_a_q, md_b_q;
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;

    // An X/Z in op or alu_op makes the if-condition non-true, so it never decodes.
    always_comb begin
        is_mult = 1'b0;
        is_div  = 1'b0;
        if (bus.op == OP_RTYPE && bus.alu_op == ALU_MULT)
            is_mult = 1'b1;
        if (bus.op == OP_RTYPE && bus.alu_op == ALU_DIV)
            is_div = 1'b1;
    end

    assign fire = bus.issue_valid & (is_mult | is_div) & ~bus.flush & (state == IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            IDLE:  if (fire) state_nxt = START;
            START: begin
                cnt_clr   = 1'b1;
                state_nxt = bus.flush ? IDLE : BUSY;
            end
            BUSY: begin
                cnt_en = 1'b1;
                if (bus.flush)
                    state_nxt = IDLE;
                else if (bus.md_ready || cnt_term)
                    state_nxt = WB;
            end
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_wb = (state == BUSY) & ~bus.flush & (bus.md_ready | cnt_term);
    assign exc_nxt  = bus.md_ready ? bus.md_exception : 1'b1;

    md_watchdog_counter #(
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W)
    ) u_watchdog (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .term  (cnt_term)
    );

    // Launch pulse and writeback are registered so they only change on the clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            md_a_q      <= '0;
            md_b_q      <= '0;
            rd_q        <= '0;
            kind_div_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
        end else begin
            ctrl_mult_q <= fire & is_mult;
            ctrl_div_q  <= fire & is_div;
            if (fire) begin
                md_a_q     <= bus.operand_a;
                md_b_q     <= bus.operand_b;
                rd_q       <= bus.rd;
                kind_div_q <= is_div;
            end
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            if (enter_wb && exc_nxt) begin
                wb_valid_q <= 1'b1;
                wb_rd_q    <= REG_RSTATUS;
                wb_data_q  <= rstatus_code(kind_div_q);
            end else if (enter_wb && rd_q != 5'd0) begin
                wb_valid_q <= 1'b1;
                wb_rd_q    <= rd_q;
                wb_data_q  <= bus.md_result;
            end
        end
    end

    assign bus.ctrl_mult = ctrl_mult_q;
    assign bus.ctrl_div  = ctrl_div_q;
    assign bus.md_a      = md_a_q;
    assign bus.md_b      = md_b_q;
    assign bus.stall     = fire | (state == START) | (state == BUSY);
    assign bus.busy      = (state != IDLE);
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Sequencing controller for the shared multi-cycle multiply/divide unit in the 5-stage pipeline.
- Decodes R-type mult/div in X and launches the unit with a one-cycle ctrl pulse.
- Holds the pipeline stalled until the unit reports ready or a watchdog expires, then issues a single writeback.
- Writeback goes either to rd with the result, or to $r30 with the rstatus code (mult=4, div=5) on exception.

Parameters:
- MAX_CYCLES, 40, watchdog limit in BUSY cycles before forced exception.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  5  X-stage opcode.
- alu_op  in  5  X-stage ALU op field.
- issue_valid  in  1  X-stage instruction valid.
- flush  in  1  squash in-flight op (branch/jump redirect).
- operand_a  in  32  rs value.
- operand_b  in  32  rt value.
- rd  in  5  destination register.
- md_result  in  32  multdiv result.
- md_exception  in  1  multdiv overflow/div-by-zero.
- md_ready  in  1  multdiv done.
- ctrl_mult  out  1  one-cycle mult launch pulse.
- ctrl_div  out  1  one-cycle div launch pulse.
- md_a  out  32  latched operand A to unit.
- md_b  out  32  latched operand B to unit.
- stall  out  1  freeze F/D/X.
- busy  out  1  state != IDLE.
- wb_valid  out  1  regfile write enable for the result.
- wb_rd  out  5  write address.
- wb_data  out  32  write data.

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0. All outputs 0, including md_a, md_b, wb_rd, wb_data.
- Decode: is_mult = op==00000 & alu_op==00110; is_div = op==00000 & alu_op==00111. Compares are exact; any X/Z bit means no match.
- fire = issue_valid & (is_mult|is_div) & ~flush & state==IDLE.
- stall (combinational) = fire | state∈{START,BUSY}. stall is low in WB so the instruction leaves X as the write lands.
- IDLE:
  - On fire, latch operand_a→md_a, operand_b→md_b, rd, kind (mult/div); go to START.
  - Non-md instructions pass untouched.
- START:
  - Exactly one of ctrl_mult/ctrl_div is high this cycle; counter cleared.
  - md_ready in START is ignored.
  - Next state: BUSY, or IDLE if flush.
- BUSY:
  - counter increments each cycle.
  - Priority: flush > md_ready > watchdog.
  - flush → IDLE with no writeback; the unit result is discarded.
  - md_ready → capture md_result and md_exception; go to WB.
  - counter==MAX_CYCLES-1 without ready → go to WB with exc=1, result=0.
- WB (exactly one cycle, then IDLE):
  - exc=1: wb_valid=1, wb_rd=30, wb_data = 4 (mult) or 5 (div); the rd write is suppressed.
  - exc=0, rd!=0: wb_valid=1, wb_rd=rd, wb_data=result.
  - exc=0, rd==0: wb_valid=0.
  - flush in WB is ignored; the instruction has already committed.
- Back-to-back md ops: the second one is held by stall/IDLE gating and fires in the cycle after WB at the earliest. Minimum occupancy is issue + START + ≥1 BUSY + WB.
- Outputs ctrl_*, wb_* are registered from state, so they are glitch-free.
- Reset asserted mid-operation returns to IDLE immediately with all outputs 0. No writeback; no pulse is re-issued.

Decomposition:
- Shared package md_sched_pkg holds:
  - state encoding IDLE/START/BUSY/WB (2 bits);
  - OP_RTYPE=00000, ALU_MULT=00110, ALU_DIV=00111;
  - RSTATUS_MULT=4, RSTATUS_DIV=5, REG_RSTATUS=30.
- One sub-module: md_watchdog_counter (CNT_W-bit, sync clear, enable, terminal flag at MAX_CYCLES-1, async active-low reset).

Test Plan:
- mult 3×7, rd=5, md_ready 17 cycles after pulse → one ctrl_mult pulse; stall held through BUSY; one WB with wb_rd=5, wb_data=21; busy returns to 0.
- div 10÷0, rd=8, md_exception=1 with ready → wb_rd=30, wb_data=5, no write to r8.
- mult, md_ready never asserted → WB after exactly MAX_CYCLES BUSY cycles, with wb_rd=30, wb_data=4.
- div issued, flush at BUSY cycle 3 → IDLE next cycle, wb_valid never high, stall drops; a later ready pulse is ignored.
- mult with rd=0, no exception → wb_valid stays 0; back-to-back div fires in the cycle after WB.
- reset driven low mid-BUSY → all outputs 0 asynchronously; after release the next mult runs normally.
